regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 113 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports, one write port, and a
// sequential clear sweep. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREAD      = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD*DATA_WIDTH-1:0] rdata,
    input  logic                        wen,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        clr_req,
    output logic                        busy,
    output logic                        wr_drop
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cidx_q, cidx_d;
    logic                    wr_drop_q, wr_drop_d;
    logic [DATA_WIDTH-1:0]   mem_q [Depth];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    wr_zero;
    logic                    wr_commit;

    assign busy    = (state_q == StClear);
    assign wr_drop = wr_drop_q;

    always_comb begin
        wr_zero   = (ZERO_REG != 0) && (waddr == '0);
        // A write only lands when idle, not colliding with a clear, and not to the zero entry.
        wr_commit = !rst && (state_q == StIdle) && wen && !clr_req && !wr_zero;

        state_d   = state_q;
        cidx_d    = cidx_q;
        wr_drop_d = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;

        if (rst) begin
            state_d = StClear;
            cidx_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    wr_drop_d = wen && clr_req;
                    if (clr_req) begin
                        state_d = StClear;
                        cidx_d  = '0;
                    end else if (wr_commit) begin
                        mem_we = 1'b1;
                    end
                end
                StClear: begin
                    wr_drop_d = wen;
                    mem_we    = 1'b1;
                    mem_waddr = cidx_q;
                    mem_wdata = '0;
                    cidx_d    = cidx_q + 1'b1;
                    if (cidx_q == '1) begin
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        cidx_q    <= cidx_d;
        wr_drop_q <= wr_drop_d;
    end

    // Storage needs no reset: the post-reset sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;

        assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_commit && (ra == waddr)) begin
                rd = wdata;
            end
`endif
            if (busy || rst || ((ZERO_REG != 0) && (ra == '0))) begin
                rd = '0;
            end
        end

        assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    end

endmodule
